// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package mdu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } mdu_state_e;

endpackage

// File: rtl/mdu_operand_cond.sv
// Operand conditioning: signedness decode, magnitudes and result sign-correction flags.
module mdu_operand_cond
  import mdu_pkg::*;
(
  input  mdu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            signed_a,
  output logic            signed_b,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            neg_prod,
  output logic            neg_quo,
  output logic            neg_rem
);

  logic neg_a;
  logic neg_b;

  // MUL is treated as signed x signed; its low word is identical either way.
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      OP_MULHSU: signed_a = 1'b1;
      default: ;
    endcase
  end

  assign neg_a = signed_a & a[XLEN-1];
  assign neg_b = signed_b & b[XLEN-1];

  assign mag_a = neg_a ? -a : a;
  assign mag_b = neg_b ? -b : b;

  assign neg_prod = ~op[2] & (neg_a ^ neg_b);
  assign neg_quo  = (op == OP_DIV) & (neg_a ^ neg_b);
  assign neg_rem  = (op == OP_REM) & neg_a;

endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: fixed 32-step shift-add multiply / restoring divide.
module mdu
  import mdu_pkg::*;
#(
  parameter int CALC_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      mdu_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [5:0] LAST_STEP = 6'(CALC_CYCLES - 1);

  mdu_op_e         op_in;
  logic            signed_a;
  logic            signed_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            neg_prod;
  logic            neg_quo;
  logic            neg_rem;
  logic            div_zero_in;
  logic            overflow_in;

  mdu_state_e        state;
  logic [5:0]        counter;
  mdu_op_e           op_q;
  logic              neg_prod_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic              div_zero_q;
  logic              overflow_q;
  logic [XLEN-1:0]   mag_a_q;
  logic [XLEN-1:0]   mag_b_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_result;

  assign op_in = mdu_op_e'(mdu_op);

  mdu_operand_cond u_operand_cond (
    .op       (op_in),
    .a        (in_a),
    .b        (in_b),
    .signed_a (signed_a),
    .signed_b (signed_b),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .neg_prod (neg_prod),
    .neg_quo  (neg_quo),
    .neg_rem  (neg_rem)
  );

  assign div_zero_in = (in_b == '0);
  assign overflow_in = signed_a & signed_b & (in_a == INT_MIN) & (in_b == '1);

  // acc low half doubles as multiplier (shifted out) or dividend/quotient (shifted through).
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a_q} : '0);
  assign div_shift = {rem, acc[XLEN-1]};
  assign div_trial = div_shift - {1'b0, mag_b_q};

  assign prod_fix = neg_prod_q ? -acc : acc;
  assign quo_fix  = neg_quo_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = neg_rem_q ? -rem : rem;

  // Special cases override the iterated value; the dividend is rebuilt from its magnitude.
  always_comb begin
    fix_result = '0;
    case (op_q)
      OP_MUL: fix_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div_zero_q)      fix_result = DIV_BY_ZERO_Q;
        else if (overflow_q) fix_result = INT_MIN;
        else                 fix_result = quo_fix;
      end
      OP_REM, OP_REMU: begin
        if (div_zero_q)      fix_result = neg_rem_q ? -mag_a_q : mag_a_q;
        else if (overflow_q) fix_result = '0;
        else                 fix_result = rem_fix;
      end
      default: fix_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      counter    <= '0;
      op_q       <= OP_MUL;
      neg_prod_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      acc        <= '0;
      rem        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !kill) begin
            state      <= S_CALC;
            busy       <= 1'b1;
            counter    <= '0;
            op_q       <= op_in;
            neg_prod_q <= neg_prod;
            neg_quo_q  <= neg_quo;
            neg_rem_q  <= neg_rem;
            div_zero_q <= div_zero_in;
            overflow_q <= overflow_in;
            mag_a_q    <= mag_a;
            mag_b_q    <= mag_b;
            acc        <= {{XLEN{1'b0}}, (op_in[2] ? mag_a : mag_b)};
            rem        <= '0;
          end
        end
        S_CALC: begin
          if (kill) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            if (!op_q[2]) begin
              acc <= {mul_sum, acc[XLEN-1:1]};
            end else begin
              rem            <= div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
              acc[XLEN-1:0]  <= {acc[XLEN-2:0], ~div_trial[XLEN]};
            end
            if (counter == LAST_STEP) state <= S_FIXUP;
            else                      counter <= counter + 6'd1;
          end
        end
        S_FIXUP: begin
          if (kill) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            result <= fix_result;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
